mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester controller that shares the single-port 4x8 memory cell (rw, 2-bit address, 8-bit data in/out) between requester A and requester B.
- Arbitrates round-robin and latches the winning request.
- Sequences the memory write or read, then returns read data with a one-cycle acknowledge pulse.
- Sits between the top-level pin decode and the memory instance, replacing direct pin-to-memory wiring.

Parameters:
- AW, 2, memory address width.
- DW, 8, memory data width.
- RD_LAT, 1, memory read latency in cycles from address valid to data valid. Legal range 0..3.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low; clock clk
- req_a  input  1  requester A access request
- we_a  input  1  A write enable (1=write, 0=read)
- addr_a  input  AW  A address
- wdata_a  input  DW  A write data
- lock_a  input  1  A lock hint (used only with MEM_ARB_LOCK_EN)
- ack_a  output  1  A completion pulse
- req_b, we_b, addr_b, wdata_b, lock_b, ack_b  same as A, for requester B
- rdata  output  DW  read data, valid in the cycle ack_x is high for a read
- busy  output  1  high whenever state is not IDLE
- mem_en  output  1  memory access strobe
- mem_rw  output  1  memory rw (1=write, 0=read)
- mem_addr  output  AW  memory address
- mem_din  output  DW  memory write data
- mem_dout  input  DW  memory read data

Behaviour:
- All outputs are registered.
- Reset values:
  - ack_a, ack_b, rdata, busy, mem_en, mem_rw, mem_addr, mem_din all 0.
  - State IDLE.
  - Round-robin pointer prio = A.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester indicated by prio wins.
  - On a win, latch we/addr/wdata of the winner plus the winner ID, then go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_addr/mem_din = latched values, mem_rw = latched we.
  - Write: go to DONE.
  - Read with RD_LAT=0: rdata <= mem_dout at the end of this cycle, go to DONE.
  - Read with RD_LAT>0: go to WAIT with counter = RD_LAT-1.
- WAIT:
  - mem_en=0, mem_rw=0, mem_addr held.
  - When the counter is 0: rdata <= mem_dout, go to DONE. Otherwise decrement.
- DONE (exactly 1 cycle):
  - ack of the winner = 1; the other ack stays 0.
  - rdata holds the captured value; it is unchanged for writes.
  - prio flips to the non-winner.
  - Go to IDLE.
- mem_rw is 1 only in ISSUE of a write; it is 0 in all other cycles.
- Latency from req sampled in IDLE (cycle t) to ack:
  - Write: t+2.
  - Read: t+2+RD_LAT.
- Max throughput: one access per 3+RD_LAT cycles (read) or 3 cycles (write).
- Handshake:
  - Inputs are sampled only in IDLE. req/we/addr/wdata changes after the win are ignored.
  - Dropping req before ack does not cancel the access; ack still pulses.
  - req still high in the IDLE cycle after its ack is a new request. Requesters drop req in the ack cycle to avoid a repeat.
  - The flipped prio guarantees the other requester wins a simultaneous request next.
- rdata holds its last captured value until the next read capture.
- Reset mid-operation:
  - At the next clk edge with rst_n=0 the state returns to IDLE and all outputs return to reset values.
  - No ack is issued for the abandoned access.
  - A write already strobed in ISSUE is not retracted.
- busy = 1 in ISSUE, WAIT and DONE.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- With the macro defined: if the winner's lock input is high in DONE, prio is set to the winner instead of flipping, so a locking requester keeps back-to-back priority. A simultaneous request from the other requester waits until the winner completes an access with lock low.
- Without the macro: lock_a/lock_b are present but ignored (tie-off only), and prio always flips in DONE.

Test Plan:
- Reset, then A write: req_a=1, we_a=1, addr_a=2, wdata_a=0x5A at t0 -> mem_en=1, mem_rw=1, mem_addr=2, mem_din=0x5A at t1; ack_a=1 at t2; ack_b=0 throughout.
- A read of addr 2 after the write, RD_LAT=1 with a 1-cycle-latency memory model -> mem_en=1, mem_rw=0 at t1; ack_a=1 with rdata=0x5A at t3; busy=1 for t1..t3.
- Simultaneous req_a and req_b writes (A: addr 0, 0x11; B: addr 1, 0x22), both held until acked, starting from reset -> A served first (ack_a at t2); B granted in the next IDLE (ack_b at t5); reads then return 0x11 and 0x22.
- Continuous req_a and req_b for 6 accesses -> acks strictly alternate A,B,A,B,A,B.
- rst_n=0 asserted in WAIT of a B read -> next cycle all outputs 0, state IDLE, no ack_b; a following req_a is served with A priority.
- With MEM_ARB_LOCK_EN defined: lock_a=1, req_a and req_b both held -> A acked 3 times consecutively; lock_a dropped -> next ack is B. Without the macro the same stimulus gives alternating acks.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin two-requester front end for a single-port memory: latches the winner, sequences the access, pulses ack.
// Optional MEM_ARB_LOCK_EN lets a winner holding its lock input keep priority for back-to-back accesses.
module mem_arbiter #(
    parameter int AW     = 2,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    input  logic          lock_a,
    output logic          ack_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    input  logic          lock_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;     // 0 = A has priority, 1 = B
    logic          win_q, win_d;       // winner of the current access, 0 = A
    logic          we_q, we_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_rw_q, mem_rw_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          grant_b;
    logic          to_done;
    logic          lock_win;

`ifdef MEM_ARB_LOCK_EN
    assign lock_win = win_q ? lock_b : lock_a;
`else
    logic lock_unused;
    assign lock_unused = lock_a | lock_b;
    assign lock_win    = 1'b0;
`endif

    // B wins when it is alone, or when both ask and B holds priority
    assign grant_b = (req_b && !req_a) || (req_a && req_b && prio_q);

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        win_d      = win_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        mem_en_d   = 1'b0;
        mem_rw_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        to_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    win_d      = grant_b;
                    we_d       = grant_b ? we_b : we_a;
                    mem_addr_d = grant_b ? addr_b : addr_a;
                    mem_din_d  = grant_b ? wdata_b : wdata_a;
                    mem_en_d   = 1'b1;
                    mem_rw_d   = grant_b ? we_b : we_a;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    to_done = 1'b1;
                end else if (RD_LAT == 0) begin
                    rdata_d = mem_dout;
                    to_done = 1'b1;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = mem_dout;
                    to_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                prio_d  = lock_win ? win_q : ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (to_done) begin
            state_d = DONE;
        end
        ack_a_d = to_done && !win_q;
        ack_b_d = to_done && win_q;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= 2'd0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            win_q      <= win_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign mem_en   = mem_en_q;
    assign mem_rw   = mem_rw_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
